seg_scan_ctrl: RTL and testbench

//   Scan controller for the 8-digit multiplexed 7-segment display on the 100 MHz board clock.

---
 rtl/seg_scan_ctrl.sv | 178 +++++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_ctrl.sv
// ============================================================================
//  Module   : seg_scan_ctrl
//  Brief    : 8-digit multiplexed 7-segment scan controller with a per-frame
//             sequential double-dabble binary-to-BCD converter.
//             Optional macro: LEADING_ZERO_BLANK_EN (blank leading zero digits).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module seg_scan_ctrl #(
   parameter int DIGIT_TICKS = 100_000,
   parameter int NUM_W       = 14
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [NUM_W-1:0] num,
   input  logic [7:0]       dp_mask,
   output logic [6:0]       cathode,
   output logic [7:0]       anode,
   output logic             dp,
   output logic             busy
);

   localparam int                TICK_W    = $clog2(DIGIT_TICKS);
   localparam int                SR_W      = NUM_W + 20;
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(DIGIT_TICKS - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ADJ   = 2'd1,
      S_SHIFT = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t            state_q,       state_d;
   logic [TICK_W-1:0] tick_cnt_q,    tick_cnt_d;
   logic [2:0]        digit_idx_q,   digit_idx_d;
   logic              frame_start_q, frame_start_d;
   logic [SR_W-1:0]   sr_q,          sr_d;
   logic [3:0]        iter_q,        iter_d;
   logic [19:0]       pending_q,     pending_d;
   logic [19:0]       display_q,     display_d;
   logic [7:0]        anode_q,       anode_d;
   logic [6:0]        cathode_q,     cathode_d;
   logic              dp_q,          dp_d;

   logic              tick_last;
   logic              digit_on;
   logic [3:0]        digit_val;

   function automatic logic [6:0] seg7(input logic [3:0] d);
      case (d)
         4'd0:    seg7 = 7'b1000000;
         4'd1:    seg7 = 7'b1111001;
         4'd2:    seg7 = 7'b0100100;
         4'd3:    seg7 = 7'b0110000;
         4'd4:    seg7 = 7'b0011001;
         4'd5:    seg7 = 7'b0010010;
         4'd6:    seg7 = 7'b0000010;
         4'd7:    seg7 = 7'b1111000;
         4'd8:    seg7 = 7'b0000000;
         4'd9:    seg7 = 7'b0010000;
         default: seg7 = 7'h7F;
      endcase
   endfunction

   // Scan timing; display only takes the new result at a slot boundary
   always_comb begin
      tick_last     = (tick_cnt_q == TICK_LAST);
      tick_cnt_d    = tick_last ? '0 : tick_cnt_q + 1'b1;
      digit_idx_d   = tick_last ? digit_idx_q + 3'd1 : digit_idx_q;
      frame_start_d = tick_last && (digit_idx_q == 3'd7);
      display_d     = tick_last ? pending_q : display_q;
   end

   always_comb begin
      state_d   = state_q;
      sr_d      = sr_q;
      iter_d    = iter_q;
      pending_d = pending_q;
      case (state_q)
         S_IDLE: begin
            if (frame_start_q) begin
               sr_d    = {20'd0, num};
               iter_d  = 4'(NUM_W);
               state_d = S_ADJ;
            end
         end
         S_ADJ: begin
            for (int i = 0; i < 5; i++) begin
               if (sr_q[NUM_W + 4*i +: 4] >= 4'd5)
                  sr_d[NUM_W + 4*i +: 4] = sr_q[NUM_W + 4*i +: 4] + 4'd3;
            end
            state_d = S_SHIFT;
         end
         S_SHIFT: begin
            sr_d    = sr_q << 1;
            iter_d  = iter_q - 4'd1;
            state_d = (iter_q == 4'd1) ? S_DONE : S_ADJ;
         end
         S_DONE: begin
            pending_d = sr_q[SR_W-1 -: 20];
            state_d   = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

`ifdef LEADING_ZERO_BLANK_EN
   logic [4:1] nib_nz;
   logic       lz_blank;

   // A digit is blank when it and every digit above it are zero
   always_comb begin
      for (int i = 1; i < 5; i++)
         nib_nz[i] = |display_q[4*i +: 4];
      case (digit_idx_q)
         3'd1:    lz_blank = ~|nib_nz[4:1];
         3'd2:    lz_blank = ~|nib_nz[4:2];
         3'd3:    lz_blank = ~|nib_nz[4:3];
         3'd4:    lz_blank = ~nib_nz[4];
         default: lz_blank = 1'b0;
      endcase
   end
`endif

   always_comb begin
      digit_val = 4'd0;
      for (int i = 0; i < 5; i++) begin
         if (digit_idx_q == 3'(i))
            digit_val = display_q[4*i +: 4];
      end
      digit_on  = (digit_idx_q <= 3'd4);
      anode_d   = digit_on ? ~(8'd1 << digit_idx_q) : 8'hFF;
      cathode_d = digit_on ? seg7(digit_val) : 7'h7F;
`ifdef LEADING_ZERO_BLANK_EN
      if (lz_blank)
         cathode_d = 7'h7F;
`endif
      dp_d      = digit_on ? ~dp_mask[digit_idx_q] : 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_IDLE;
         tick_cnt_q    <= '0;
         digit_idx_q   <= 3'd0;
         frame_start_q <= 1'b1;
         sr_q          <= '0;
         iter_q        <= 4'd0;
         pending_q     <= 20'd0;
         display_q     <= 20'd0;
         anode_q       <= 8'hFF;
         cathode_q     <= 7'h7F;
         dp_q          <= 1'b1;
      end else begin
         state_q       <= state_d;
         tick_cnt_q    <= tick_cnt_d;
         digit_idx_q   <= digit_idx_d;
         frame_start_q <= frame_start_d;
         sr_q          <= sr_d;
         iter_q        <= iter_d;
         pending_q     <= pending_d;
         display_q     <= display_d;
         anode_q       <= anode_d;
         cathode_q     <= cathode_d;
         dp_q          <= dp_d;
      end
   end

   assign anode   = anode_q;
   assign cathode = cathode_q;
   assign dp      = dp_q;
   assign busy    = (state_q != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_seg_scan_ctrl.sv
// ============================================================================
//  Module   : tb_seg_scan_ctrl
//  Brief    : Scoreboard bench for seg_scan_ctrl (DIGIT_TICKS=4, NUM_W=14).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_seg_scan_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [13:0] num;
   logic [7:0]  dp_mask;
   logic [6:0]  cathode;
   logic [7:0]  anode;
   logic        dp;
   logic        busy;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      logic [7:0] an;
      logic [6:0] ca;
      logic       dp;
   } pres_t;

   pres_t exp_q[$];
   int    busy_q[$];
   int    cap;
   logic  mon_en = 1'b0;

   seg_scan_ctrl #(.DIGIT_TICKS(4), .NUM_W(14)) dut (
      .clk     (clk),
      .rst     (rst),
      .num     (num),
      .dp_mask (dp_mask),
      .cathode (cathode),
      .anode   (anode),
      .dp      (dp),
      .busy    (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, required finish");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [6:0] seg_of(input int d);
      case (d)
         0: seg_of = 7'b1000000;  1: seg_of = 7'b1111001;
         2: seg_of = 7'b0100100;  3: seg_of = 7'b0110000;
         4: seg_of = 7'b0011001;  5: seg_of = 7'b0010010;
         6: seg_of = 7'b0000010;  7: seg_of = 7'b1111000;
         8: seg_of = 7'b0000000;  9: seg_of = 7'b0010000;
         default: seg_of = 7'h7F;
      endcase
   endfunction

   // Expected digit presentations for one frame showing value v
   task automatic push_frame(input int v, input logic [7:0] m, input int ndig);
      pres_t      e;
      logic [7:0] one;
      int         p;
      one = 8'd1;
      for (int d = 0; d < ndig; d++) begin
         p = 1;
         for (int j = 0; j < d; j++) p = p * 10;
         e.an = ~(one << d);
         e.ca = seg_of((v / p) % 10);
`ifdef LEADING_ZERO_BLANK_EN
         if (d > 0 && v < p) e.ca = 7'h7F;
`endif
         e.dp = ~m[d];
         exp_q.push_back(e);
      end
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Called just after frame edge 25; covers the following frame
   task automatic next_frame(input int n, input logic [7:0] m, input int mid_at, input int mid_num);
      push_frame(cap, m, 5);
      busy_q.push_back(29);
      num     = 14'(n);
      dp_mask = m;
      cap     = n;
      if (mid_at > 0) begin
         wait_cyc(7 + mid_at);
         num = 14'(mid_num);
         wait_cyc(25 - mid_at);
      end else begin
         wait_cyc(32);
      end
   endtask

   task automatic frame_with_reset(input int n, input logic [7:0] m, input int rst_at, input int rst_num);
      int nd;
      nd = (rst_at - 1) / 4 + 1;
      if (nd > 5) nd = 5;
      push_frame(cap, m, nd);
      busy_q.push_back(rst_at);
      num     = 14'(n);
      dp_mask = m;
      wait_cyc(7 + rst_at);
      rst = 1'b1;
      num = 14'(rst_num);
      wait_cyc(1);
      rst = 1'b0;
      push_frame(0, m, 5);
      busy_q.push_back(29);
      cap = rst_num;
      wait_cyc(25);
   endtask

   // Monitor: one presentation per newly enabled digit, one busy pulse length per conversion
   initial begin
      logic [7:0] prev_an;
      int         busy_cnt;
      pres_t      e;
      int         bexp;
      prev_an  = 8'hFF;
      busy_cnt = 0;
      forever begin
         @(negedge clk);
         if (mon_en) begin
            chk("anode_hi_bits", {29'd0, anode[7:5]}, 32'h7);
            if (anode === 8'hFF) begin
               chk("idle_cathode", {25'd0, cathode}, 32'h7F);
               chk("idle_dp", {31'd0, dp}, 32'h1);
            end
            if (anode !== prev_an && anode !== 8'hFF) begin
               if (exp_q.size() == 0) begin
                  n_checks++;
                  n_errors++;
                  $display("FAIL pres_unexpected: got anode %0h, required no presentation", anode);
               end else begin
                  e = exp_q.pop_front();
                  chk("pres_anode", {24'd0, anode}, {24'd0, e.an});
                  chk("pres_cathode", {25'd0, cathode}, {25'd0, e.ca});
                  chk("pres_dp", {31'd0, dp}, {31'd0, e.dp});
               end
            end
            prev_an = anode;
            if (busy === 1'b1) begin
               busy_cnt++;
            end else if (busy_cnt > 0) begin
               if (busy_q.size() == 0) begin
                  n_checks++;
                  n_errors++;
                  $display("FAIL busy_unexpected: got pulse of %0d, required none", busy_cnt);
               end else begin
                  bexp = busy_q.pop_front();
                  chk("busy_len", 32'(busy_cnt), 32'(bexp));
               end
               busy_cnt = 0;
            end
         end
      end
   end

   initial begin
      rst     = 1'b1;
      num     = 14'd1234;
      dp_mask = 8'h00;
      repeat (3) begin
         @(posedge clk);
         mon_en = 1'b1;
         @(negedge clk);
         chk("rst_anode", {24'd0, anode}, 32'hFF);
         chk("rst_cathode", {25'd0, cathode}, 32'h7F);
         chk("rst_dp", {31'd0, dp}, 32'h1);
         chk("rst_busy", {31'd0, busy}, 32'h0);
      end
      rst = 1'b0;
      push_frame(0, 8'h00, 5);
      busy_q.push_back(29);
      cap = 1234;
      @(posedge clk);
      @(negedge clk);
      chk("rel_busy", {31'd0, busy}, 32'h1);
      chk("rel_anode", {24'd0, anode}, 32'hFE);
      repeat (24) @(posedge clk);
      #1;

      next_frame(1234,  8'h00, 0, 0);
      next_frame(16383, 8'h00, 0, 0);
      next_frame(16383, 8'h00, 0, 0);
      next_frame(100,   8'h00, 10, 200);
      next_frame(200,   8'h00, 0, 0);
      next_frame(5,     8'h04, 0, 0);
      next_frame(5,     8'h04, 0, 0);
      next_frame(42,    8'h81, 0, 0);
      frame_with_reset(9999, 8'h01, 15, 7);
      next_frame(0,     8'h00, 0, 0);
      next_frame(0,     8'h00, 0, 0);

      wait_cyc(6);
      mon_en = 1'b0;
      chk("pres_queue_drained", 32'(exp_q.size()), 32'd0);
      chk("busy_queue_drained", 32'(busy_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
